// File: rtl/pio_sched_pkg.sv
// pio_sched_pkg: shared state encoding, PIO data address and default widths for pio_read_scheduler.
package pio_sched_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;
  localparam int PIO_DATA_ADDR = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_e;
endpackage

// File: rtl/pio_rr_arbiter.sv
// pio_rr_arbiter: round-robin pick-next starting after the last winner, with the registered pointer.
module pio_rr_arbiter
  import pio_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [IW-1:0]      win_o,
  output logic               any_o
);
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  assign any_o = |req_i;
  // Walk the ring backwards so the requester closest after the pointer is assigned last.
  always_comb begin
    win_o = ptr_q;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[idx]) win_o = idx;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= IW'(NUM_REQ - 1);
    else if (en_i && any_o) ptr_q <= win_o;
endmodule

// File: rtl/pio_read_scheduler.sv
// pio_read_scheduler: round-robin sharing of one Avalon-MM PIO input slave between NUM_REQ requesters.
// Define PIO_CHANGE_DETECT_EN for idle background reads of the data register with change detection.
module pio_read_scheduler
  import pio_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         pio_address,
  input  logic [DATA_W-1:0]         pio_readdata,
  output logic                      change_evt,
  output logic [DATA_W-1:0]         shadow_data
);
  localparam int IW = $clog2(NUM_REQ);
`ifdef PIO_CHANGE_DETECT_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif
  state_e state_q;
  logic [IW-1:0] win_q, arb_win;
  logic [NUM_REQ-1:0] gnt_q, rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ADDR_W-1:0] addr_q, addr_sel;
  logic busy_q, bg_q, arb_any, arb_en;
  assign arb_en = (state_q == IDLE) || (state_q == DONE);
  pio_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk_i(clk), .rst_i(reset), .req_i(req), .en_i(arb_en), .win_o(arb_win), .any_o(arb_any)
  );
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_win == IW'(i)) addr_sel = req_addr[i*ADDR_W +: ADDR_W];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      win_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      bg_q <= 1'b0;
    end else begin
      gnt_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE, DONE:
          if (arb_any) begin
            state_q <= ISSUE;
            bg_q <= 1'b0;
            win_q <= arb_win;
            addr_q <= addr_sel;
            gnt_q <= NUM_REQ'(1) << arb_win;
            busy_q <= 1'b1;
          end else if (CD_EN && state_q == IDLE) begin
            state_q <= ISSUE;
            bg_q <= 1'b1;
            addr_q <= ADDR_W'(PIO_DATA_ADDR);
            busy_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        ISSUE: state_q <= CAPTURE;
        default: begin
          state_q <= DONE;
          if (!bg_q) begin
            rsp_data_q <= pio_readdata;
            rsp_valid_q <= NUM_REQ'(1) << win_q;
          end
        end
      endcase
    end
`ifdef PIO_CHANGE_DETECT_EN
  logic evt_q;
  logic [DATA_W-1:0] shadow_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      evt_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      evt_q <= 1'b0;
      if (state_q == CAPTURE && bg_q && pio_readdata != shadow_q) begin
        evt_q <= 1'b1;
        shadow_q <= pio_readdata;
      end
    end
  assign change_evt = evt_q;
  assign shadow_data = shadow_q;
`else
  assign change_evt = 1'b0;
  assign shadow_data = '0;
`endif
  assign gnt = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign busy = busy_q;
  assign pio_address = addr_q;
endmodule

// File: tb/tb_pio_read_scheduler.sv
// tb_pio_read_scheduler: directed and randomized checks of pio_read_scheduler against a transaction-level model.
module tb_pio_read_scheduler;
  localparam int N = 4;
  localparam int AW = 2;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [DW-1:0] rsp_data, shadow_data, pio_readdata;
  logic busy, change_evt;
  logic [AW-1:0] pio_address;
  logic [7:0] port = 8'h00;
  int checks = 0;
  int passes = 0;

  pio_read_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .pio_address(pio_address), .pio_readdata(pio_readdata),
    .change_evt(change_evt), .shadow_data(shadow_data)
  );

  always #5 clk = ~clk;

  // Input-only PIO: address 0 returns the zero-extended 8-bit port, other addresses read 0.
  always @(posedge clk or posedge reset)
    if (reset) pio_readdata <= '0;
    else pio_readdata <= (pio_address == 0) ? {24'b0, port} : '0;

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, busy, pio_address, rsp_data, change_evt, shadow_data} !== '0)
      $display("FAIL reset_outputs: gnt=%b rsp_valid=%b busy=%b addr=%0d data=%h evt=%b shadow=%h, required all 0",
               gnt, rsp_valid, busy, pio_address, rsp_data, change_evt, shadow_data);
    else passes++;
    reset = 1'b0;
    req = '0;
  endtask

  task automatic test_single();
    do_reset();
    port = 8'h5A;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) $display("FAIL single_gnt: gnt=%b busy=%b, required 0001/1", gnt, busy);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h0000005A)
      $display("FAIL single_rsp: rsp_valid=%b data=%h, required 0001/0000005a", rsp_valid, rsp_data);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0 || rsp_data !== 32'h5A)
      $display("FAIL single_idle: busy=%b rsp_valid=%b data=%h, required 0/0000/5a", busy, rsp_valid, rsp_data);
    else passes++;
  endtask

  task automatic test_contention();
    logic [N-1:0] eg, ev;
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      eg = (c % 3 == 1) ? N'(1) << ((c / 3) % N) : '0;
      ev = (c % 3 == 0) ? N'(1) << ((c / 3 - 1) % N) : '0;
      checks++;
      if (gnt !== eg || rsp_valid !== ev || busy !== 1'b1)
        $display("FAIL contention c%0d: gnt=%b rsp_valid=%b busy=%b, required %b/%b/1", c, gnt, rsp_valid, busy, eg, ev);
      else passes++;
    end
    req = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0100;
    req_addr = 8'b00_01_00_00;
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0100) $display("FAIL withdraw_gnt: gnt=%b, required 0100", gnt);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0100) $display("FAIL withdraw_rsp: rsp_valid=%b, required 0100", rsp_valid);
    else passes++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== '0 || rsp_valid !== '0 || busy !== 1'b0)
        $display("FAIL withdraw_quiet c%0d: gnt=%b rsp_valid=%b busy=%b, required 0/0/0", c, gnt, rsp_valid, busy);
      else passes++;
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    port = 8'h11;
    req = 4'b0001;
    req_addr = 8'b00_00_00_11;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, rsp_valid, busy, pio_address, rsp_data} !== '0)
      $display("FAIL abort_async: gnt=%b rsp_valid=%b busy=%b addr=%0d data=%h, required all 0",
               gnt, rsp_valid, busy, pio_address, rsp_data);
    else passes++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0) $display("FAIL abort_no_rsp: rsp_valid=%b, required 0000", rsp_valid);
    else passes++;
    reset = 1'b0;
    req = 4'b1001;
    req_addr = '0;
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0001) $display("FAIL abort_priority: gnt=%b, required 0001", gnt);
    else passes++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_address();
    do_reset();
    port = 8'h77;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_data !== 32'h77) $display("FAIL addr0_data: data=%h, required 00000077", rsp_data);
    else passes++;
    req = 4'b0010;
    req_addr = 8'b00_00_11_00;
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0010 || pio_address !== 2'd3)
      $display("FAIL addr3_issue: gnt=%b addr=%0d, required 0010/3", gnt, pio_address);
    else passes++;
    @(negedge clk);
    checks++;
    if (pio_address !== 2'd3) $display("FAIL addr3_capture: addr=%0d, required 3", pio_address);
    else passes++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== '0)
      $display("FAIL addr3_rsp: rsp_valid=%b data=%h, required 0010/00000000", rsp_valid, rsp_data);
    else passes++;
    @(negedge clk);
    checks++;
    if (pio_address !== 2'd3) $display("FAIL addr_hold: addr=%0d, required 3", pio_address);
    else passes++;
  endtask

  // Reference: a transaction occupies three cycles (grant, capture, respond); arbitration happens
  // whenever no transaction is running or in its final cycle, searching round-robin after the last winner.
  task automatic test_random();
    int p = 0;
    int ptr = N - 1;
    int win = 0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] mdata = '0;
    logic [DW-1:0] edata = '0;
    logic [N-1:0] eg, ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(0, 15));
      req_addr = N*AW'($urandom);
      port = 8'($urandom);
      @(posedge clk);
      if (p == 0 || p == 3) begin
        if (req != '0) begin
          for (int k = 1; k <= N; k++)
            if (req[(ptr + k) % N]) begin
              win = (ptr + k) % N;
              break;
            end
          ptr = win;
          maddr = AW'(req_addr >> (win * AW));
          p = 1;
        end else p = 0;
      end else if (p == 1) begin
        mdata = (maddr == 0) ? {24'b0, port} : '0;
        p = 2;
      end else begin
        edata = mdata;
        p = 3;
      end
      @(negedge clk);
      eg = (p == 1) ? N'(1) << win : '0;
      ev = (p == 3) ? N'(1) << win : '0;
      checks++;
      if (gnt !== eg || rsp_valid !== ev || busy !== (p != 0) || pio_address !== maddr || rsp_data !== edata)
        $display("FAIL random c%0d: gnt=%b rsp_valid=%b busy=%b addr=%0d data=%h, required %b/%b/%b/%0d/%h",
                 c, gnt, rsp_valid, busy, pio_address, rsp_data, eg, ev, p != 0, maddr, edata);
      else passes++;
    end
    req = '0;
  endtask

  task automatic test_change_detect();
    int pulses;
    logic no_gnt;
    do_reset();
    port = 8'h00;
    pulses = 0;
    no_gnt = 1'b1;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(change_evt);
      if (gnt !== '0 || rsp_valid !== '0) no_gnt = 1'b0;
    end
    checks++;
    if (pulses != 0) $display("FAIL cd_stable_zero: pulses=%0d, required 0", pulses);
    else passes++;
    port = 8'h3C;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(change_evt);
      if (gnt !== '0 || rsp_valid !== '0) no_gnt = 1'b0;
    end
    checks++;
    if (pulses != 1 || shadow_data !== 32'h3C)
      $display("FAIL cd_change: pulses=%0d shadow=%h, required 1/0000003c", pulses, shadow_data);
    else passes++;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(change_evt);
    end
    checks++;
    if (pulses != 1 || no_gnt !== 1'b1)
      $display("FAIL cd_no_repeat: pulses=%0d no_gnt=%b, required 1/1", pulses, no_gnt);
    else passes++;
  endtask

  initial begin
    test_reset();
`ifdef PIO_CHANGE_DETECT_EN
    test_change_detect();
`else
    test_single();
    test_contention();
    test_withdraw();
    test_reset_abort();
    test_address();
    test_random();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
